pipe_sub: RTL and testbench

PIPE_SUB -- requirements
Module: pipe_sub

---
 rtl/pipe_sub_pkg.sv | 12 +
 rtl/pipe_sub_slice.sv | 37 +++
 rtl/pipe_sub.sv | 150 +++++++++++++++
 tb/tb_pipe_sub.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_sub_pkg.sv
// Shared defaults and stage bookkeeping type for the pipelined subtractor.
package pipe_sub_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned STAGES_DEF = 4;

    typedef struct packed {
        logic valid;
        logic borrow;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_sub_slice.sv
// One SW-bit ripple subtract slice with registered difference and borrow-out.
module pipe_sub_slice #(
    parameter int unsigned SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          bin,
    output logic [SW-1:0] d,
    output logic          bout
);

    logic [SW-1:0] d_c;
    logic          brw;

    always_comb begin
        d_c = '0;
        brw = bin;
        for (int i = 0; i < SW; i++) begin
            d_c[i] = a[i] ^ b[i] ^ brw;
            brw    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            bout <= 1'b0;
        end else if (en) begin
            d    <= d_c;
            bout <= brw;
        end
    end

endmodule

// File: rtl/pipe_sub.sv
// Bit-sliced pipelined subtractor with skewed operands and a global stall enable.
// Define PIPE_SUB_ABS_EN to add an output stage that returns |i0 - i1|.
module pipe_sub
    import pipe_sub_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Br,
    output logic             Z
);

    localparam int unsigned SW = WIDTH / STAGES;

    stage_ctl_t [STAGES-1:0] ctl;
    logic       [STAGES-1:0] valid_q;
    logic       [WIDTH-1:0]  diff_all;
    logic                    adv;

    // One enable for every register: a stall freezes the whole pipe.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (adv) begin
            valid_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= ctl[k-1].valid;
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic [SW-1:0] a_use;
        logic [SW-1:0] b_use;
        logic [SW-1:0] d_slice;
        logic [SW-1:0] d_out;
        logic          bin;
        logic          bout;

        // Slice k consumes operand bits delayed k cycles to meet its borrow-in.
        if (k == 0) begin : g_no_skew
            assign a_use = i0[k*SW +: SW];
            assign b_use = i1[k*SW +: SW];
            assign bin   = 1'b0;
        end else begin : g_skew
            logic [SW-1:0] a_dly [k];
            logic [SW-1:0] b_dly [k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < k; j++) begin
                        a_dly[j] <= '0;
                        b_dly[j] <= '0;
                    end
                end else if (adv) begin
                    a_dly[0] <= i0[k*SW +: SW];
                    b_dly[0] <= i1[k*SW +: SW];
                    for (int j = 1; j < k; j++) begin
                        a_dly[j] <= a_dly[j-1];
                        b_dly[j] <= b_dly[j-1];
                    end
                end
            end

            assign a_use = a_dly[k-1];
            assign b_use = b_dly[k-1];
            assign bin   = ctl[k-1].borrow;
        end

        pipe_sub_slice #(
            .SW (SW)
        ) u_slice (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .a     (a_use),
            .b     (b_use),
            .bin   (bin),
            .d     (d_slice),
            .bout  (bout)
        );

        // Lower slices finish early; hold their bits until the top slice catches up.
        if (k == STAGES - 1) begin : g_no_deskew
            assign d_out = d_slice;
        end else begin : g_deskew
            logic [SW-1:0] d_dly [STAGES-1-k];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < STAGES - 1 - k; j++) begin
                        d_dly[j] <= '0;
                    end
                end else if (adv) begin
                    d_dly[0] <= d_slice;
                    for (int j = 1; j < STAGES - 1 - k; j++) begin
                        d_dly[j] <= d_dly[j-1];
                    end
                end
            end

            assign d_out = d_dly[STAGES-2-k];
        end

        assign ctl[k]                = '{valid: valid_q[k], borrow: bout};
        assign diff_all[k*SW +: SW] = d_out;
    end

`ifdef PIPE_SUB_ABS_EN
    logic             abs_valid_q;
    logic             abs_br_q;
    logic [WIDTH-1:0] abs_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abs_valid_q <= 1'b0;
            abs_br_q    <= 1'b0;
            abs_d_q     <= '0;
        end else if (adv) begin
            abs_valid_q <= ctl[STAGES-1].valid;
            abs_br_q    <= ctl[STAGES-1].borrow;
            abs_d_q     <= ctl[STAGES-1].borrow ? -diff_all : diff_all;
        end
    end

    assign out_valid = abs_valid_q;
    assign D         = abs_d_q;
    assign Br        = abs_br_q;
`else
    assign out_valid = ctl[STAGES-1].valid;
    assign D         = diff_all;
    assign Br        = ctl[STAGES-1].borrow;
`endif

    // Gated by out_valid so the cleared pipe does not report a zero result.
    assign Z = out_valid && (D == '0);

endmodule

// File: tb/tb_pipe_sub.sv
// Self-checking bench for pipe_sub: directed table, stall, reset and random scoreboard runs.
module tb_pipe_sub;

`ifdef PIPE_SUB_ABS_EN
    localparam bit ABS = 1'b1;
    localparam int LAT = 5;
`else
    localparam bit ABS = 1'b0;
    localparam int LAT = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        Br;
    logic        Z;

    pipe_sub #(
        .WIDTH  (32),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i0        (i0),
        .i1        (i1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Br        (Br),
        .Z         (Z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] d;
        logic        br;
        logic        z;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d_raw;
        logic [31:0] d_abs;
        logic        br;
        logic        z;
    } vec_t;

    int   vectors;
    int   miscompares;
    int   rcv;
    res_t exp_q[$];

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        r.br = (a < b);
        r.d  = a - b;
        if (ABS && r.br) r.d = b - a;
        r.z  = (r.d == 32'd0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    // Caller sets inputs just after a rising edge; this samples handshakes and advances one clock.
    task automatic cyc(output bit acc);
        res_t e;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            rcv++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_out: got D=0x%h, expected no result", D);
            end else begin
                e = exp_q.pop_front();
                check("out_D", D, e.d);
                check("out_Br", 32'(Br), 32'(e.br));
                check("out_Z", 32'(Z), 32'(e.z));
            end
        end
        if (acc) exp_q.push_back(model(i0, i1));
        @(posedge clk);
        #1;
    endtask

    vec_t        tv [8];
    logic [31:0] sa [8];
    logic [31:0] sb [8];

    initial begin
        bit          acc;
        int          n;
        int          sent;
        bit          held;
        logic [31:0] held_d;

        vectors     = 0;
        miscompares = 0;
        rcv         = 0;

        tv[0] = '{32'h0000000A, 32'h00000003, 32'h00000007, 32'h00000007, 1'b0, 1'b0};
        tv[1] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0};
        tv[2] = '{32'h12345678, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
        tv[3] = '{32'h00010000, 32'h00000001, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0};
        tv[4] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0};
        tv[5] = '{32'h80000000, 32'h7FFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        tv[6] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
        tv[7] = '{32'h00000100, 32'h00000200, 32'hFFFFFF00, 32'h00000100, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        i0        = '0;
        i1        = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_D", D, 32'd0);
        check("rst_Br", 32'(Br), 32'd0);
        check("rst_Z", 32'(Z), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table: one operand pair at a time, latency and result checked.
        for (int t = 0; t < 8; t++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            i0        = tv[t].a;
            i1        = tv[t].b;
            #1;
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("tbl_latency", 32'(n), 32'(LAT));
            check("tbl_D", D, ABS ? tv[t].d_abs : tv[t].d_raw);
            check("tbl_Br", 32'(Br), 32'(tv[t].br));
            check("tbl_Z", 32'(Z), 32'(tv[t].z));
            @(posedge clk);
            #1;
        end

        // Back-to-back burst with the consumer stalled for cycles 5-8.
        for (int k = 0; k < 8; k++) begin
            sa[k] = $urandom();
            sb[k] = $urandom();
        end
        rcv  = 0;
        sent = 0;
        held = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            out_ready = !(c >= 5 && c <= 8);
            in_valid  = (sent < 8);
            i0        = sa[sent % 8];
            i1        = sb[sent % 8];
            #1;
            if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
            if (held) check("stall_hold_D", D, held_d);
            held   = out_valid && !out_ready;
            held_d = D;
            cyc(acc);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("stall_received", 32'(rcv), 32'd8);
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0: begin i0 = $urandom(); i1 = i0; end
                1: begin i0 = 32'd0; i1 = $urandom_range(0, 3); end
                2: begin i0 = 32'h1 << $urandom_range(0, 31); i1 = $urandom_range(0, 2); end
                default: begin i0 = $urandom(); i1 = $urandom(); end
            endcase
            cyc(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) cyc(acc);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with transactions in flight and a result waiting at the output.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < LAT; c++) begin
            i0 = $urandom();
            i1 = $urandom();
            cyc(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_D", D, 32'd0);
        check("mid_rst_Br", 32'(Br), 32'd0);
        check("mid_rst_Z", 32'(Z), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) cyc(acc);
        check("post_rst_no_stale", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
